// File: rtl/calc_ctrl_fsm_pkg.sv
// Shared types and constants for the calculator sequencer: state encoding,
// push-button bit positions, ALU opcodes and a one-hot to index helper.
package calc_ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_RD_A  = 3'd2,
      ST_RD_B  = 3'd3,
      ST_OPSEL = 3'd4,
      ST_EXEC  = 3'd5,
      ST_SHOW  = 3'd6,
      ST_ERR   = 3'd7
   } state_t;

   localparam int PB_W      = 10;
   localparam int PB_SHIFT0 = 0;
   localparam int PB_SHIFT1 = 1;
   localparam int PB_WRITE  = 2;
   localparam int PB_READ   = 3;
   localparam int PB_ADD    = 4;
   localparam int PB_SUB    = 5;
   localparam int PB_REG0   = 6;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   function automatic logic [1:0] reg_index(input logic [3:0] sel);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/calc_ctrl_fsm_if.sv
// Button, register-file, ALU and display signals of the calculator sequencer.
// master = sequencer side, slave = environment (buttons, reg file, ALU, display).
interface calc_ctrl_fsm_if #(parameter int DATA_W = 8);

   logic [calc_ctrl_fsm_pkg::PB_W-1:0] pb_strobe;
   logic              rf_we;
   logic [1:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [1:0]        rf_raddr_a;
   logic [1:0]        rf_raddr_b;
   logic              alu_start;
   logic [1:0]        alu_op;
   logic              alu_done;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic              alu_neg;
   logic [DATA_W-1:0] disp_val;
   logic              red;
   logic              blue;
   logic              busy;

   modport master (
      input  pb_strobe, alu_done, alu_result, alu_carry, alu_neg,
      output rf_we, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b,
             alu_start, alu_op, disp_val, red, blue, busy
   );

   modport slave (
      output pb_strobe, alu_done, alu_result, alu_carry, alu_neg,
      input  rf_we, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b,
             alu_start, alu_op, disp_val, red, blue, busy
   );

endinterface

// File: rtl/calc_ctrl_fsm_timeout_ctr.sv
// ALU watchdog: down-counter reloaded while cleared, expired flags the
// TIMEOUT-th enabled cycle after the last clear.
module calc_ctrl_fsm_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= CW'(TIMEOUT - 1);
      end else if (clear) begin
         cnt_q <= CW'(TIMEOUT - 1);
      end else if (enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/calc_ctrl_fsm.sv
// Calculator sequencer: digit entry, register writes, operand select and ALU
// launch with timeout; all outputs registered.
//  state | meaning
//  IDLE  | after reset, waiting for write or read mode
//  WRITE | shifting digits into entry, pb[6+i] stores entry to R[i]
//  RD_A  | waiting for operand A register select
//  RD_B  | waiting for operand B register select
//  OPSEL | waiting for ADD/SUB
//  EXEC  | ALU running, strobes ignored, watchdog armed
//  SHOW  | displaying ALU result
//  ERR   | ALU timed out, red held
module calc_ctrl_fsm
   import calc_ctrl_fsm_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 4,
   parameter int MAX_DISP    = 99,
   parameter int ALU_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            nrst,
   calc_ctrl_fsm_if.master bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] entry_q, entry_d;
   logic [DATA_W-1:0] disp_q, disp_d;
   logic              we_q, we_d;
   logic [1:0]        waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        ra_q, ra_d;
   logic [1:0]        rb_q, rb_d;
   logic              start_q, start_d;
   logic [1:0]        op_q, op_d;
   logic              red_q, red_d;
   logic              blue_q, blue_d;

   logic [PB_W-1:0]   pb;
   logic [3:0]        reg_sel;
   logic              reg_hit;
   logic [1:0]        reg_idx;
   logic [DATA_W-1:0] entry_shift;
   logic              expired;

   // Multi-button cycles are dropped as if nothing was pressed.
   assign pb          = $onehot(bus.pb_strobe) ? bus.pb_strobe : '0;
   assign reg_sel     = 4'(pb[PB_REG0 +: NUM_REGS]);
   assign reg_hit     = |reg_sel;
   assign reg_idx     = reg_index(reg_sel);
   assign entry_shift = {entry_q[DATA_W-2:0], pb[PB_SHIFT1]};

   calc_ctrl_fsm_timeout_ctr #(.TIMEOUT(ALU_TIMEOUT)) u_timeout (
      .clk     (clk),
      .nrst    (nrst),
      .clear   (state_q != ST_EXEC),
      .enable  (state_q == ST_EXEC),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         entry_q <= '0;
         disp_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         start_q <= 1'b0;
         op_q    <= OP_ADD;
         red_q   <= 1'b0;
         blue_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         disp_q  <= disp_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         start_q <= start_d;
         op_q    <= op_d;
         red_q   <= red_d;
         blue_q  <= blue_d;
      end
   end

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      disp_d  = disp_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      start_d = 1'b0;
      op_d    = op_q;
      red_d   = red_q;
      blue_d  = blue_q;

      // Any mode change wipes entry, display and status together.
      if (pb[PB_WRITE] && (state_q != ST_EXEC)) begin
         state_d = ST_WRITE;
         entry_d = '0;
         disp_d  = '0;
         red_d   = 1'b0;
         blue_d  = 1'b0;
      end else if (pb[PB_READ] && (state_q inside {ST_IDLE, ST_WRITE, ST_SHOW, ST_ERR})) begin
         state_d = ST_RD_A;
         entry_d = '0;
         disp_d  = '0;
         red_d   = 1'b0;
         blue_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_WRITE: begin
               if (pb[PB_SHIFT0] || pb[PB_SHIFT1]) begin
                  entry_d = entry_shift;
                  disp_d  = entry_shift;
                  red_d   = entry_shift > DATA_W'(MAX_DISP);
               end else if (reg_hit && (entry_q <= DATA_W'(MAX_DISP))) begin
                  we_d    = 1'b1;
                  waddr_d = reg_idx;
                  wdata_d = entry_q;
                  entry_d = '0;
                  disp_d  = '0;
                  red_d   = 1'b0;
               end
            end
            ST_RD_A: begin
               if (reg_hit) begin
                  ra_d    = reg_idx;
                  state_d = ST_RD_B;
               end
            end
            ST_RD_B: begin
               if (reg_hit) begin
                  rb_d    = reg_idx;
                  state_d = ST_OPSEL;
               end
            end
            ST_OPSEL: begin
               if (pb[PB_ADD] || pb[PB_SUB]) begin
                  op_d    = pb[PB_SUB] ? OP_SUB : OP_ADD;
                  start_d = 1'b1;
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (bus.alu_done) begin
                  disp_d  = bus.alu_result;
                  blue_d  = bus.alu_neg;
                  red_d   = bus.alu_carry | (bus.alu_result > DATA_W'(MAX_DISP));
                  state_d = ST_SHOW;
               end else if (expired) begin
                  red_d   = 1'b1;
                  disp_d  = '0;
                  state_d = ST_ERR;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rf_we      = we_q;
   assign bus.rf_waddr   = waddr_q;
   assign bus.rf_wdata   = wdata_q;
   assign bus.rf_raddr_a = ra_q;
   assign bus.rf_raddr_b = rb_q;
   assign bus.alu_start  = start_q;
   assign bus.alu_op     = op_q;
   assign bus.disp_val   = disp_q;
   assign bus.red        = red_q;
   assign bus.blue       = blue_q;
   assign bus.busy       = (state_q == ST_EXEC);

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Bench for calc_ctrl_fsm: button sequences drive the FSM, a small ALU and
// register model predict writes, launches and results held in queues.
module tb_calc_ctrl_fsm;
   import calc_ctrl_fsm_pkg::*;

   typedef struct packed {logic [1:0] addr; logic [7:0] data;} wr_t;
   typedef struct packed {logic [1:0] a; logic [1:0] b; logic [1:0] op;} ln_t;
   typedef struct packed {logic [7:0] val; logic red; logic blue;} res_t;

   logic tb_clk;
   logic nrst;
   int   n_chk;
   int   n_err;

   wr_t  wr_q[$];
   ln_t  ln_q[$];
   res_t res_q[$];
   logic res_due;

   logic [7:0] entry_m;
   logic [7:0] rf_m[4];
   logic [1:0] la, lb, lop;

   calc_ctrl_fsm_if #(.DATA_W(8)) bus();

   calc_ctrl_fsm #(
      .DATA_W(8), .NUM_REGS(4), .MAX_DISP(99), .ALU_TIMEOUT(16)
   ) dut (
      .clk  (tb_clk),
      .nrst (nrst),
      .bus  (bus.master)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic press_mask(input logic [9:0] mask);
      bus.pb_strobe = mask;
      tick();
      bus.pb_strobe = '0;
   endtask

   task automatic press(input int idx);
      logic [9:0] one;
      one = 10'd1;
      press_mask(one << idx);
   endtask

   task automatic shift(input logic b);
      entry_m = {entry_m[6:0], b};
      press(b ? PB_SHIFT1 : PB_SHIFT0);
   endtask

   task automatic sel_write(input int i);
      if (entry_m <= 8'd99) wr_q.push_back('{addr: 2'(i), data: entry_m});
      if (entry_m <= 8'd99) entry_m = '0;
      press(PB_REG0 + i);
   endtask

   task automatic launch(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
      press(PB_READ);
      entry_m = '0;
      press(PB_REG0 + int'(a));
      press(PB_REG0 + int'(b));
      la = a; lb = b; lop = op;
      ln_q.push_back('{a: a, b: b, op: op});
      press(op == OP_SUB ? PB_SUB : PB_ADD);
   endtask

   task automatic alu_reply();
      logic [8:0] sum;
      logic       carry;
      res_t       r;
      tick();
      tick();
      carry = 1'b0;
      if (lop == OP_ADD) begin
         sum    = {1'b0, rf_m[la]} + {1'b0, rf_m[lb]};
         r.val  = sum[7:0];
         carry  = sum[8];
         r.blue = 1'b0;
      end else if (rf_m[la] >= rf_m[lb]) begin
         r.val  = rf_m[la] - rf_m[lb];
         r.blue = 1'b0;
      end else begin
         r.val  = rf_m[lb] - rf_m[la];
         r.blue = 1'b1;
      end
      r.red = carry | (r.val > 8'd99);
      res_q.push_back(r);
      bus.alu_done   = 1'b1;
      bus.alu_result = r.val;
      bus.alu_carry  = carry;
      bus.alu_neg    = r.blue;
      tick();
      bus.alu_done   = 1'b0;
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_ctl"}, 32'({bus.rf_we, bus.alu_start, bus.red, bus.blue, bus.busy}), 0);
      chk({tag, "_addr"}, 32'({bus.rf_waddr, bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op}), 0);
      chk({tag, "_data"}, 32'({bus.rf_wdata, bus.disp_val}), 0);
   endtask

   // Scoreboard consumers: every DUT write, launch and result is matched in order.
   always @(negedge tb_clk) begin
      if (nrst) begin
         if (bus.rf_we) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 32'(bus.rf_we), 0);
            else begin
               wr_t e;
               e = wr_q.pop_front();
               chk("wr_addr", 32'(bus.rf_waddr), 32'(e.addr));
               chk("wr_data", 32'(bus.rf_wdata), 32'(e.data));
               rf_m[e.addr] = e.data;
            end
         end
         if (bus.alu_start) begin
            if (ln_q.size() == 0) chk("start_unexpected", 32'(bus.alu_start), 0);
            else begin
               ln_t l;
               l = ln_q.pop_front();
               chk("start_raddr", 32'({bus.rf_raddr_a, bus.rf_raddr_b}), 32'({l.a, l.b}));
               chk("start_op", 32'(bus.alu_op), 32'(l.op));
            end
         end
         if (res_due) begin
            if (res_q.size() == 0) chk("res_unexpected", 32'(res_q.size()), 1);
            else begin
               res_t r;
               r = res_q.pop_front();
               chk("res_disp", 32'(bus.disp_val), 32'(r.val));
               chk("res_red_blue", 32'({bus.red, bus.blue}), 32'({r.red, r.blue}));
            end
         end
      end
      res_due = nrst && bus.alu_done && bus.busy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_err = 0; res_due = 1'b0;
      entry_m = '0;
      for (int i = 0; i < 4; i++) rf_m[i] = '0;
      la = '0; lb = '0; lop = '0;
      bus.pb_strobe = '0; bus.alu_done = 1'b0; bus.alu_result = '0;
      bus.alu_carry = 1'b0; bus.alu_neg = 1'b0;
      nrst = 1'b1;

      // reset asserted mid-cycle, held, released
      #3 nrst = 1'b0;
      #1 chk_zero_outs("rst_async");
      tick();
      chk_zero_outs("rst_held");
      nrst = 1'b1;
      tick();
      chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk_zero_outs("rst_release");

      // write R0=1, R1=2, then ADD
      press(PB_WRITE); entry_m = '0;
      chk("write_state", 32'(dut.state_q), 32'(ST_WRITE));
      for (int i = 0; i < 8; i++) shift(1'b0);
      shift(1'b1);
      chk("entry_disp_1", 32'(bus.disp_val), 32'(entry_m));
      sel_write(0);
      chk("disp_after_wr", 32'(bus.disp_val), 0);
      shift(1'b1); shift(1'b0);
      chk("entry_disp_2", 32'(bus.disp_val), 32'(entry_m));
      sel_write(1);
      launch(2'd0, 2'd1, OP_ADD);
      chk("exec_busy", 32'(bus.busy), 1);
      alu_reply();
      chk("show_state", 32'({dut.state_q, bus.busy}), 32'({ST_SHOW, 1'b0}));

      // SUB giving a negative result
      launch(2'd0, 2'd1, OP_SUB);
      alu_reply();
      press(PB_WRITE); entry_m = '0;
      chk("blue_cleared", 32'({bus.blue, bus.red}), 0);
      chk("disp_cleared", 32'(bus.disp_val), 0);

      // entry boundary: 99 writes, 100 and above does not
      for (int i = 6; i >= 0; i--) begin
         logic [6:0] v;
         v = 7'd99;
         shift(v[i]);
      end
      chk("entry_99_red", 32'(bus.red), 0);
      sel_write(3);
      for (int i = 0; i < 7; i++) shift(1'b1);
      chk("entry_127_red", 32'(bus.red), 1);
      chk("entry_127_disp", 32'(bus.disp_val), 32'(entry_m));
      sel_write(2);
      chk("ovf_red_held", 32'({bus.red, bus.disp_val}), 32'({1'b1, entry_m}));
      shift(1'b1); shift(1'b0);
      chk("entry_msb_discard", 32'(bus.disp_val), 32'(entry_m));
      press(PB_WRITE); entry_m = '0;
      chk("ovf_clear", 32'({bus.red, bus.disp_val}), 0);

      // ALU timeout: busy for exactly 16 cycles from alu_start
      launch(2'd1, 2'd3, OP_ADD);
      for (int i = 1; i < 16; i++) tick();
      chk("tmo_last_exec", 32'({bus.busy, bus.red}), 32'({1'b1, 1'b0}));
      tick();
      chk("tmo_err", 32'({dut.state_q, bus.red, bus.busy, bus.disp_val}),
          32'({ST_ERR, 1'b1, 1'b0, 8'd0}));
      press(PB_READ);
      chk("tmo_exit", 32'({dut.state_q, bus.red}), 32'({ST_RD_A, 1'b0}));

      // simultaneous strobes, strobes during EXEC, reset mid-EXEC
      press(PB_WRITE); entry_m = '0;
      shift(1'b1);
      press_mask(10'b00_0000_0011);
      chk("multi_shift", 32'(bus.disp_val), 32'(entry_m));
      press_mask(10'b00_0100_0100);
      chk("multi_wr", 32'({dut.state_q, bus.disp_val}), 32'({ST_WRITE, entry_m}));
      launch(2'd2, 2'd3, OP_SUB);
      press(PB_WRITE);
      chk("exec_ignores", 32'({dut.state_q, bus.busy}), 32'({ST_EXEC, 1'b1}));
      #2 nrst = 1'b0;
      #1 chk_zero_outs("rst_exec");
      tick();
      nrst = 1'b1;
      tick();
      chk("rst_exec_idle", 32'(dut.state_q), 32'(ST_IDLE));
      bus.alu_done = 1'b1; bus.alu_result = 8'd77; bus.alu_neg = 1'b1;
      tick();
      bus.alu_done = 1'b0;
      tick();
      chk("done_ignored", 32'({dut.state_q, bus.disp_val, bus.blue}), 32'({ST_IDLE, 8'd0, 1'b0}));

      chk("wr_q_left", 32'(wr_q.size()), 0);
      chk("ln_q_left", 32'(ln_q.size()), 0);
      chk("res_q_left", 32'(res_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
